// File: rtl/cordic_phase_disc.sv
// Vectoring-mode CORDIC discriminator: I/Q in, phase / magnitude / per-sample phase delta out.
// Define CORDIC_DISC_GAIN_COMP_EN to add a 1/K amplitude-correction register stage.
module cordic_phase_disc #(
  parameter int IDW   = 12,
  parameter int ODW   = IDW + 2,
  parameter int AW    = 20,
  parameter int STAGE = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pi_dv,
  input  logic [IDW-1:0]   pi_x,
  input  logic [IDW-1:0]   pi_y,
  input  logic [ODW-1:0]   sq_thr,
  output logic             po_dv,
  output logic [AW-1:0]    po_phase,
  output logic [ODW-1:0]   po_amp,
  output logic [AW-1:0]    po_freq,
  output logic             po_freq_vld
);

  // Fractional guard bits below the integer LSB keep shift truncation from biasing the angle.
  localparam int GB = 10;
  localparam int DW = ODW + GB;
  localparam logic signed [DW-1:0] HALF_LSB = DW'(1 << (GB - 1));

  // Arctangent table held in a 2^32-per-turn scale, rescaled and rounded to AW bits.
  function automatic logic [AW-1:0] atan_lut(input int i);
    logic [63:0] t;
    case (i)
      0:  t = 64'd536870912;
      1:  t = 64'd316933406;
      2:  t = 64'd167458907;
      3:  t = 64'd85004756;
      4:  t = 64'd42667331;
      5:  t = 64'd21354465;
      6:  t = 64'd10679838;
      7:  t = 64'd5340245;
      8:  t = 64'd2670163;
      9:  t = 64'd1335087;
      10: t = 64'd667544;
      11: t = 64'd333772;
      12: t = 64'd166886;
      13: t = 64'd83443;
      14: t = 64'd41722;
      15: t = 64'd20861;
      16: t = 64'd10430;
      17: t = 64'd5215;
      18: t = 64'd2608;
      19: t = 64'd1304;
      default: t = 64'd0;
    endcase
    t = (t + (64'd1 << (31 - AW))) >> (32 - AW);
    return t[AW-1:0];
  endfunction

  logic signed [DW-1:0] x_q    [0:STAGE];
  logic signed [DW-1:0] y_q    [0:STAGE];
  logic [AW-1:0]        z_q    [0:STAGE];
  logic                 dv_q   [0:STAGE];
  logic                 zero_q [0:STAGE];

  logic signed [DW-1:0] x_ext;
  logic signed [DW-1:0] y_ext;
  logic signed [DW-1:0] x0_d;
  logic signed [DW-1:0] y0_d;
  logic [AW-1:0]        z0_d;
  logic                 zero0_d;

  // Pre-rotation folds the left half-plane onto the right by adding half a turn.
  always_comb begin
    x_ext   = {{(ODW-IDW){pi_x[IDW-1]}}, pi_x, {GB{1'b0}}};
    y_ext   = {{(ODW-IDW){pi_y[IDW-1]}}, pi_y, {GB{1'b0}}};
    zero0_d = (pi_x == '0) && (pi_y == '0);
    x0_d    = x_ext;
    y0_d    = y_ext;
    z0_d    = '0;
    if (x_ext[DW-1]) begin
      x0_d = -x_ext;
      y0_d = -y_ext;
      z0_d = {1'b1, {(AW-1){1'b0}}};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q[0]    <= '0;
      y_q[0]    <= '0;
      z_q[0]    <= '0;
      dv_q[0]   <= 1'b0;
      zero_q[0] <= 1'b0;
    end else begin
      x_q[0]    <= x0_d;
      y_q[0]    <= y0_d;
      z_q[0]    <= z0_d;
      dv_q[0]   <= pi_dv;
      zero_q[0] <= zero0_d;
    end
  end

  genvar gi;
  generate
    for (gi = 1; gi <= STAGE; gi++) begin : g_stage
      localparam logic [AW-1:0] ATAN_C = atan_lut(gi - 1);
      logic signed [DW-1:0] x_d;
      logic signed [DW-1:0] y_d;
      logic [AW-1:0]        z_d;

      // Rotate toward the x axis; z accumulates the angle removed.
      always_comb begin
        if (y_q[gi-1][DW-1]) begin
          x_d = x_q[gi-1] - (y_q[gi-1] >>> (gi - 1));
          y_d = y_q[gi-1] + (x_q[gi-1] >>> (gi - 1));
          z_d = z_q[gi-1] - ATAN_C;
        end else begin
          x_d = x_q[gi-1] + (y_q[gi-1] >>> (gi - 1));
          y_d = y_q[gi-1] - (x_q[gi-1] >>> (gi - 1));
          z_d = z_q[gi-1] + ATAN_C;
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          x_q[gi]    <= '0;
          y_q[gi]    <= '0;
          z_q[gi]    <= '0;
          dv_q[gi]   <= 1'b0;
          zero_q[gi] <= 1'b0;
        end else begin
          x_q[gi]    <= x_d;
          y_q[gi]    <= y_d;
          z_q[gi]    <= z_d;
          dv_q[gi]   <= dv_q[gi-1];
          zero_q[gi] <= zero_q[gi-1];
        end
      end
    end
  endgenerate

  logic [ODW-1:0] amp_raw;
  logic [AW-1:0]  phase_raw;

  // A zero vector leaves z at the table sum, so it is forced to a defined 0.
  always_comb begin
    amp_raw   = '0;
    phase_raw = '0;
    if (!zero_q[STAGE]) begin
      phase_raw = z_q[STAGE];
      if (!x_q[STAGE][DW-1]) begin
        amp_raw = ODW'((x_q[STAGE] + HALF_LSB) >>> GB);
      end
    end
  end

  logic [ODW-1:0] amp_pre;
  logic [AW-1:0]  phase_pre;
  logic           dv_pre;

`ifdef CORDIC_DISC_GAIN_COMP_EN
  logic [ODW-1:0] g_amp_d;
  logic [ODW-1:0] g_amp_q;
  logic [AW-1:0]  g_phase_q;
  logic           g_dv_q;

  // 19898 / 2^15 ~= 1/K for the accumulated micro-rotation gain.
  always_comb begin
    g_amp_d = ODW'(((ODW+15)'(amp_raw) * (ODW+15)'(19898) + (ODW+15)'(1 << 14)) >> 15);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      g_amp_q   <= '0;
      g_phase_q <= '0;
      g_dv_q    <= 1'b0;
    end else begin
      g_amp_q   <= g_amp_d;
      g_phase_q <= phase_raw;
      g_dv_q    <= dv_q[STAGE];
    end
  end

  assign amp_pre   = g_amp_q;
  assign phase_pre = g_phase_q;
  assign dv_pre    = g_dv_q;
`else
  assign amp_pre   = amp_raw;
  assign phase_pre = phase_raw;
  assign dv_pre    = dv_q[STAGE];
`endif

  logic           po_dv_d,    po_dv_q;
  logic [AW-1:0]  po_phase_d, po_phase_q;
  logic [ODW-1:0] po_amp_d,   po_amp_q;
  logic [AW-1:0]  po_freq_d,  po_freq_q;
  logic           po_fvld_d,  po_fvld_q;
  logic [AW-1:0]  hist_d,     hist_q;
  logic           hist_vld_d, hist_vld_q;
  logic           squelch;

  // Bubbles leave history untouched; a squelched sample breaks the history chain.
  always_comb begin
    squelch    = (sq_thr != '0) && (amp_pre < sq_thr);
    po_dv_d    = dv_pre;
    po_phase_d = po_phase_q;
    po_amp_d   = po_amp_q;
    po_freq_d  = po_freq_q;
    po_fvld_d  = 1'b0;
    hist_d     = hist_q;
    hist_vld_d = hist_vld_q;
    if (dv_pre) begin
      po_phase_d = phase_pre;
      po_amp_d   = amp_pre;
      if (squelch) begin
        po_freq_d  = '0;
        hist_vld_d = 1'b0;
      end else begin
        po_freq_d  = phase_pre - hist_q;
        po_fvld_d  = hist_vld_q;
        hist_d     = phase_pre;
        hist_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      po_dv_q    <= 1'b0;
      po_phase_q <= '0;
      po_amp_q   <= '0;
      po_freq_q  <= '0;
      po_fvld_q  <= 1'b0;
      hist_q     <= '0;
      hist_vld_q <= 1'b0;
    end else begin
      po_dv_q    <= po_dv_d;
      po_phase_q <= po_phase_d;
      po_amp_q   <= po_amp_d;
      po_freq_q  <= po_freq_d;
      po_fvld_q  <= po_fvld_d;
      hist_q     <= hist_d;
      hist_vld_q <= hist_vld_d;
    end
  end

  assign po_dv       = po_dv_q;
  assign po_phase    = po_phase_q;
  assign po_amp      = po_amp_q;
  assign po_freq     = po_freq_q;
  assign po_freq_vld = po_fvld_q;

endmodule

// File: tb/tb_cordic_phase_disc.sv
// Directed bench for cordic_phase_disc: static vectors, latency, bubbles, squelch, reset, NCO loopback.
module tb_cordic_phase_disc;
  localparam int IDW   = 12;
  localparam int ODW   = 14;
  localparam int AW    = 20;
  localparam int STAGE = 16;
  localparam int FULL  = 1 << AW;
`ifdef CORDIC_DISC_GAIN_COMP_EN
  localparam int LAT   = STAGE + 3;
  localparam int AMP1K = 1024;
  localparam int AMP10 = 10;
`else
  localparam int LAT   = STAGE + 2;
  localparam int AMP1K = 1686;
  localparam int AMP10 = 16;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           pi_dv = 1'b0;
  logic [IDW-1:0] pi_x = '0;
  logic [IDW-1:0] pi_y = '0;
  logic [ODW-1:0] sq_thr = '0;
  logic           po_dv;
  logic [AW-1:0]  po_phase;
  logic [ODW-1:0] po_amp;
  logic [AW-1:0]  po_freq;
  logic           po_freq_vld;

  cordic_phase_disc #(.IDW(IDW), .ODW(ODW), .AW(AW), .STAGE(STAGE)) dut (
    .clk(clk), .rst_n(rst_n), .pi_dv(pi_dv), .pi_x(pi_x), .pi_y(pi_y), .sq_thr(sq_thr),
    .po_dv(po_dv), .po_phase(po_phase), .po_amp(po_amp), .po_freq(po_freq),
    .po_freq_vld(po_freq_vld)
  );

  always #5 clk = ~clk;

  typedef struct {
    int phase;
    int amp;
    int freq;
    bit fvld;
    int cyc;
  } rec_t;

  rec_t q[$];
  int   dq[$];
  int   cyc = 0;
  int   errs = 0;
  int   checks = 0;

  function automatic int sx(input logic [AW-1:0] v);
    return v[AW-1] ? int'(v) - FULL : int'(v);
  endfunction

  function automatic int wdiff(input int a, input int b);
    int d;
    d = (a - b) & (FULL - 1);
    if (d >= FULL / 2) d = d - FULL;
    return d;
  endfunction

  function automatic int rnd(input real r);
    return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    rec_t r;
    if (po_dv) begin
      r.phase = int'(po_phase);
      r.amp   = int'(po_amp);
      r.freq  = sx(po_freq);
      r.fvld  = po_freq_vld;
      r.cyc   = cyc;
      q.push_back(r);
    end
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_near(input string tag, input int obs, input int exp, input int tol);
    int d;
    bit ok;
    d  = wdiff(obs, exp);
    ok = (d <= tol) && (d >= -tol);
    checks++;
    assert (ok === 1'b1) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d+-%0d", tag, obs, exp, tol);
    end
  endtask

  task automatic send(input int x, input int y);
    @(negedge clk);
    pi_dv = 1'b1;
    pi_x  = IDW'(x);
    pi_y  = IDW'(y);
    dq.push_back(cyc);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      pi_dv = 1'b0;
    end
  endtask

  task automatic flush();
    q.delete();
    dq.delete();
  endtask

  initial begin
    int exp_ph [3];
    int incs [3];
    int p, sum, bad, lim;
    real ang;

    exp_ph = '{262144, 524288, 786432};
    incs   = '{128, 1024, -512};

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_dv", int'(po_dv), 0);
    check_eq("rst_fvld", int'(po_freq_vld), 0);
    check_eq("rst_phase", int'(po_phase), 0);
    check_eq("rst_amp", int'(po_amp), 0);
    check_eq("rst_freq", int'(po_freq), 0);
    rst_n = 1'b1;
    flush();

    // Single pulse: latency, first output not frequency-valid, (1024,0)
    send(1024, 0);
    idle(LAT + 4);
    check_eq("pulse_count", q.size(), 1);
    if (q.size() >= 1) begin
      check_eq("pulse_latency", q[0].cyc - dq[0], LAT);
      check_eq("pulse_fvld", int'(q[0].fvld), 0);
      check_near("ph_0", q[0].phase, 0, 8);
      check_near("amp_1024", q[0].amp, AMP1K, 4);
    end
    flush();

    // Remaining static vectors back to back
    send(0, 1024);
    send(-1024, 0);
    send(0, -1024);
    idle(LAT + 4);
    check_eq("static_count", q.size(), 3);
    if (q.size() >= 3) begin
      for (int k = 0; k < 3; k++) begin
        check_eq($sformatf("static_lat%0d", k), q[k].cyc - dq[k], LAT);
        check_near($sformatf("static_ph%0d", k), q[k].phase, exp_ph[k], 8);
        check_eq($sformatf("static_fvld%0d", k), int'(q[k].fvld), 1);
        check_near($sformatf("static_freq%0d", k), q[k].freq, 262144, 16);
      end
    end
    flush();

    // Bubbles between valid samples at phase ~0, ~1000, ~2000
    send(1836, 0);
    send(1836, 11);
    idle(5);
    send(1836, 22);
    idle(LAT + 4);
    check_eq("bub_count", q.size(), 3);
    if (q.size() >= 3) begin
      check_near("bub_freq1", q[1].freq, 1000, 8);
      check_near("bub_freq2", q[2].freq, 1000, 8);
      check_eq("bub_fvld2", int'(q[2].fvld), 1);
      check_eq("bub_gap", q[2].cyc - q[1].cyc, 6);
    end
    flush();

    // Squelch with threshold 100
    sq_thr = ODW'(100);
    send(10, 0);
    send(1836, 0);
    send(1836, 11);
    idle(LAT + 4);
    sq_thr = '0;
    check_eq("sq_count", q.size(), 3);
    if (q.size() >= 3) begin
      check_eq("sq_weak_fvld", int'(q[0].fvld), 0);
      check_eq("sq_weak_freq", q[0].freq, 0);
      check_near("sq_weak_amp", q[0].amp, AMP10, 2);
      check_eq("sq_next_fvld", int'(q[1].fvld), 0);
      check_eq("sq_2nd_fvld", int'(q[2].fvld), 1);
      check_near("sq_2nd_freq", q[2].freq, 1000, 8);
    end
    flush();

    // Mid-stream reset drops samples in flight
    for (int k = 0; k < 5; k++) send(1024, 100 * k);
    @(negedge clk);
    pi_dv = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("mrst_dv", int'(po_dv), 0);
    check_eq("mrst_fvld", int'(po_freq_vld), 0);
    check_eq("mrst_phase", int'(po_phase), 0);
    check_eq("mrst_amp", int'(po_amp), 0);
    check_eq("mrst_freq", int'(po_freq), 0);
    rst_n = 1'b1;
    flush();
    send(0, 1024);
    send(0, 0);
    idle(LAT + 4);
    check_eq("mrst_count", q.size(), 2);
    if (q.size() >= 2) begin
      check_eq("mrst_latency", q[0].cyc - dq[0], LAT);
      check_eq("mrst_first_fvld", int'(q[0].fvld), 0);
      check_eq("zero_fvld", int'(q[1].fvld), 1);
      check_eq("zero_phase", q[1].phase, 0);
      check_eq("zero_amp", q[1].amp, 0);
      check_near("zero_freq", q[1].freq, -262144, 16);
    end
    flush();

    // NCO loopback: phase starts so that the 2^AW -> 0 wrap falls mid-run
    for (int t = 0; t < 3; t++) begin
      p = ((-incs[t] * 128) % FULL + FULL) % FULL;
      for (int n = 0; n < 260; n++) begin
        ang = 6.283185307179586 * real'(p) / real'(FULL);
        send(rnd(2000.0 * $cos(ang)), rnd(2000.0 * $sin(ang)));
        p = ((p + incs[t]) % FULL + FULL) % FULL;
      end
      idle(LAT + 4);
      check_eq($sformatf("nco%0d_count", t), q.size(), 260);
      if (q.size() >= 260) begin
        check_eq($sformatf("nco%0d_continuous", t), q[259].cyc - q[0].cyc, 259);
        sum = 0;
        bad = 0;
        lim = ((incs[t] < 0) ? -incs[t] : incs[t]) + 200;
        for (int n = 2; n < 258; n++) begin
          sum += q[n].freq;
          if (q[n].freq > lim || q[n].freq < -lim || !q[n].fvld) bad++;
        end
        check_near($sformatf("nco%0d_mean_x256", t), sum, 256 * incs[t], 512);
        check_eq($sformatf("nco%0d_outliers", t), bad, 0);
      end
      flush();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
